// File: rtl/rv_hazard_scoreboard.sv
// rv_hazard_scoreboard: per-register result-latency scoreboard that
// generates stall/flush controls for the 5-stage RV32 pipeline.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   issue_valid_d       D instruction wants to advance to E
//   rs1_d/rs2_d         D source registers, qualified by rs*_used_d
//   rd_d/rd_we_d        D destination and its write enable
//   lat_d               cycles after E entry until result is forwardable
//   pcsrc_e             taken branch/jump resolved in E
//   mc_busy_i           multi-cycle unit occupied, E must hold
//   stall_f/stall_d     hold PC and IF/ID
//   flush_d/flush_e     clear IF/ID, bubble into ID/EX
//   pending_o           bit r set while register r has a result in flight
//   stall_cnt_o         saturating count of stall_d cycles
module rv_hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int LAT_W    = 3,
  parameter bit FWD_EN   = 1'b1,
  parameter int WB_EXTRA = 2,
  parameter int PERF_W   = 32,
  localparam int IDX_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_d,
  input  logic [IDX_W-1:0]  rs1_d,
  input  logic [IDX_W-1:0]  rs2_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic [IDX_W-1:0]  rd_d,
  input  logic              rd_we_d,
  input  logic [LAT_W-1:0]  lat_d,
  input  logic              pcsrc_e,
  input  logic              mc_busy_i,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [NREGS-1:0]  pending_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  logic [NREGS-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0]            effLat;
  logic                        rs1Hz;
  logic                        rs2Hz;
  logic                        rawHz;
  logic                        hazard;
  logic                        fire;

  // Without forwarding, consumers must wait for write-back; the extra
  // delay saturates so a long op never wraps into "no hazard".
  if (FWD_EN) begin : gFwd
    assign effLat = lat_d;
  end else begin : gNoFwd
    logic [31:0] latSum;
    assign latSum = 32'(lat_d) + 32'(WB_EXTRA);
    assign effLat = (latSum > 32'(LAT_MAX)) ? LAT_MAX
                                            : latSum[LAT_W-1:0];
  end

  // cnt==1 means the result is forwardable next cycle, so only >1 stalls.
  assign rs1Hz = rs1_used_d && (rs1_d != '0)
              && (cnt[rs1_d] > LAT_W'(1));
  assign rs2Hz = rs2_used_d && (rs2_d != '0)
              && (cnt[rs2_d] > LAT_W'(1));
  assign rawHz  = issue_valid_d && (rs1Hz || rs2Hz);
  assign hazard = rawHz || mc_busy_i;

  // A redirect kills D, so it overrides any stall.
  assign stall_f = hazard && !pcsrc_e;
  assign stall_d = hazard && !pcsrc_e;
  assign flush_d = pcsrc_e;
  assign flush_e = hazard || pcsrc_e;
  assign fire    = issue_valid_d && !hazard && !pcsrc_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (fire && rd_we_d && (rd_d == IDX_W'(r))) begin
          cnt[r] <= effLat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < NREGS; r++) begin
      pending_o[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
    end else if (stall_d && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// tb_rv_hazard_scoreboard: directed bench for the hazard scoreboard,
// one forwarding build and one no-forwarding build with a 3-bit counter.
module tb_rv_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       rs1_used_d;
  logic       rs2_used_d;
  logic [4:0] rd_d;
  logic       rd_we_d;
  logic [2:0] lat_d;
  logic       pcsrc_e;
  logic       mc_busy_i;

  logic        aStallF, aStallD, aFlushD, aFlushE;
  logic [31:0] aPend;
  logic [31:0] aStallCnt;
  logic        bStallF, bStallD, bFlushD, bFlushE;
  logic [31:0] bPend;
  logic [2:0]  bStallCnt;

  always #5 clk = ~clk;

  rv_hazard_scoreboard #(
    .NREGS(32), .LAT_W(3), .FWD_EN(1'b1),
    .WB_EXTRA(2), .PERF_W(32)
  ) dutA (
    .clk(clk), .reset(reset),
    .issue_valid_d(issue_valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rd_d(rd_d), .rd_we_d(rd_we_d), .lat_d(lat_d),
    .pcsrc_e(pcsrc_e), .mc_busy_i(mc_busy_i),
    .stall_f(aStallF), .stall_d(aStallD),
    .flush_d(aFlushD), .flush_e(aFlushE),
    .pending_o(aPend), .stall_cnt_o(aStallCnt)
  );

  rv_hazard_scoreboard #(
    .NREGS(32), .LAT_W(3), .FWD_EN(1'b0),
    .WB_EXTRA(2), .PERF_W(3)
  ) dutB (
    .clk(clk), .reset(reset),
    .issue_valid_d(issue_valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rd_d(rd_d), .rd_we_d(rd_we_d), .lat_d(lat_d),
    .pcsrc_e(pcsrc_e), .mc_busy_i(mc_busy_i),
    .stall_f(bStallF), .stall_d(bStallD),
    .flush_d(bFlushD), .flush_e(bFlushE),
    .pending_o(bPend), .stall_cnt_o(bStallCnt)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic        stall;
    logic        fd;
    logic        fe;
    logic [31:0] pend;
    logic [31:0] scnt;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(logic iv, logic [4:0] r1, logic u1,
                     logic [4:0] r2, logic u2, logic [4:0] rd,
                     logic we, logic [2:0] lat, logic pc, logic mc);
    issue_valid_d = iv;
    rs1_d = r1;
    rs1_used_d = u1;
    rs2_d = r2;
    rs2_used_d = u2;
    rd_d = rd;
    rd_we_d = we;
    lat_d = lat;
    pcsrc_e = pc;
    mc_busy_i = mc;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(string tag, bit sel, logic st, logic fd,
                      logic fe, logic [31:0] pend, logic [31:0] scnt);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.stall = st;
    e.fd = fd;
    e.fe = fe;
    e.pend = pend;
    e.scnt = scnt;
    q.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, state advances on the
  // rising edge, and new stimulus is applied 1 time unit after it.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel) begin
        chk({e.tag, ".stall_f"}, 32'(bStallF), 32'(e.stall));
        chk({e.tag, ".stall_d"}, 32'(bStallD), 32'(e.stall));
        chk({e.tag, ".flush_d"}, 32'(bFlushD), 32'(e.fd));
        chk({e.tag, ".flush_e"}, 32'(bFlushE), 32'(e.fe));
        chk({e.tag, ".pending"}, bPend, e.pend);
        chk({e.tag, ".stall_cnt"}, 32'(bStallCnt), e.scnt);
      end else begin
        chk({e.tag, ".stall_f"}, 32'(aStallF), 32'(e.stall));
        chk({e.tag, ".stall_d"}, 32'(aStallD), 32'(e.stall));
        chk({e.tag, ".flush_d"}, 32'(aFlushD), 32'(e.fd));
        chk({e.tag, ".flush_e"}, 32'(aFlushE), 32'(e.fe));
        chk({e.tag, ".pending"}, aPend, e.pend);
        chk({e.tag, ".stall_cnt"}, aStallCnt, e.scnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bitv(int r);
    return 32'(1) << r;
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    push("rst_a", 0, 0, 0, 0, 0, 0);
    push("rst_b", 1, 0, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push("rst_br_a", 0, 0, 1, 1, 0, 0);
    push("rst_br_b", 1, 0, 1, 1, 0, 0);
    cycle();
    reset = 1'b0;

    // load-use
    drv(1, 0, 0, 0, 0, 5, 1, 2, 0, 0);
    push("t1_fire", 0, 0, 0, 0, 0, 0);
    cycle();
    drv(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);
    push("t1_stall", 0, 1, 0, 1, bitv(5), 0);
    cycle();
    push("t1_go", 0, 0, 0, 0, bitv(5), 1);
    cycle();

    // ALU chain
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    push("t2_fire", 0, 0, 0, 0, bitv(6), 1);
    cycle();
    drv(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    push("t2_use", 0, 0, 0, 0, bitv(3), 1);
    cycle();
    idle();
    push("t2_clear", 0, 0, 0, 0, 0, 1);
    cycle();

    // DIV latency 6 and x0
    drv(1, 0, 0, 0, 0, 7, 1, 6, 0, 0);
    push("t3_fire", 0, 0, 0, 0, 0, 1);
    cycle();
    drv(1, 7, 1, 0, 0, 8, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      push("t3_stall", 0, 1, 0, 1, bitv(7), 32'(1 + i));
      cycle();
    end
    push("t3_go", 0, 0, 0, 0, bitv(7), 6);
    cycle();
    drv(1, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    push("t3_x0fire", 0, 0, 0, 0, bitv(8), 6);
    cycle();
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    push("t3_x0use", 0, 0, 0, 0, 0, 6);
    cycle();

    // branch priority
    drv(1, 0, 0, 0, 0, 9, 1, 3, 0, 0);
    push("t4_fire", 0, 0, 0, 0, 0, 6);
    cycle();
    drv(1, 9, 1, 0, 0, 10, 1, 5, 1, 0);
    push("t4_br", 0, 0, 1, 1, bitv(9), 6);
    cycle();
    idle();
    push("t4_nowr", 0, 0, 0, 0, bitv(9), 6);
    cycle();
    push("t4_nowr2", 0, 0, 0, 0, bitv(9), 6);
    cycle();

    // multi-cycle busy
    drv(1, 0, 0, 0, 0, 11, 1, 4, 0, 0);
    push("t5_fire", 0, 0, 0, 0, 0, 6);
    cycle();
    drv(1, 12, 1, 0, 0, 13, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      push("t5_busy", 0, 1, 0, 1, bitv(11), 32'(6 + i));
      cycle();
    end
    drv(1, 12, 1, 0, 0, 13, 1, 2, 0, 0);
    push("t5_go", 0, 0, 0, 0, bitv(11), 9);
    cycle();
    idle();
    push("t5_done", 0, 0, 0, 0, bitv(13), 9);
    cycle();

    // no-forwarding build
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    push("t6_rst_a", 0, 0, 0, 0, 0, 0);
    push("t6_fire", 1, 0, 0, 0, 0, 0);
    cycle();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    push("t6_stall0", 1, 1, 0, 1, bitv(4), 0);
    cycle();
    push("t6_stall1", 1, 1, 0, 1, bitv(4), 1);
    cycle();
    push("t6_go", 1, 0, 0, 0, bitv(4), 2);
    cycle();
    drv(1, 0, 0, 0, 0, 5, 1, 6, 0, 0);
    push("t6_sat_fire", 1, 0, 0, 0, 0, 2);
    cycle();
    drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      push("t6_sat", 1, 1, 0, 1, bitv(5), 32'((2 + i > 7) ? 7 : 2 + i));
      cycle();
    end
    push("t6_sat_go", 1, 0, 0, 0, bitv(5), 7);
    cycle();
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    push("t6_m_fire", 1, 0, 0, 0, 0, 7);
    cycle();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    push("t6_m_stall", 1, 1, 0, 1, bitv(4), 7);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    push("t6_post_rst", 1, 0, 0, 0, 0, 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
